// File: rtl/trigger_seq_gen.sv
// Trigger sequence generator: arm pulse, programmable delay, strobe with
// alternating b/c qualifier held across both strobe edges, plus sequence/error counters.
module trigger_seq_gen #(
    parameter int unsigned DLY_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DLY_W-1:0] delay,
    input  logic             inject_err,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] seq_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] cnt_n;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dly_n;
    logic             err_q;
    logic             err_n;
    logic             sel;
    logic             sel_n;
    logic [CNT_W-1:0] seq_n;
    logic [CNT_W-1:0] errc_n;
    logic             a_n;
    logic             b_n;
    logic             c_n;
    logic             d_n;
    logic             busy_n;
    logic             done_n;

    // State, parameters of the running sequence and all outputs are registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dly_q     <= '0;
            err_q     <= 1'b0;
            sel       <= 1'b0;
            seq_count <= '0;
            err_count <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            d         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dly_q     <= dly_n;
            err_q     <= err_n;
            sel       <= sel_n;
            seq_count <= seq_n;
            err_count <= errc_n;
            a         <= a_n;
            b         <= b_n;
            c         <= c_n;
            d         <= d_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next state; outputs are decoded from the next state so they align with it
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dly_n   = dly_q;
        err_n   = err_q;
        sel_n   = sel;
        seq_n   = seq_count;
        errc_n  = err_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ARM;
                    dly_n   = delay;
                    err_n   = inject_err;
                end
            end
            ARM: begin
                if (dly_q == '0) begin
                    state_n = STROBE;
                end else begin
                    state_n = WAIT;
                    cnt_n   = dly_q;
                end
            end
            WAIT: begin
                cnt_n = cnt - DLY_W'(1);
                if (cnt == DLY_W'(1)) begin
                    state_n = STROBE;
                end
            end
            STROBE: state_n = HOLD;
            HOLD: begin
                // Counters and sel change on entry to DONE so they are visible with done
                state_n = DONE;
                seq_n   = seq_count + CNT_W'(1);
                sel_n   = ~sel;
                if (err_q) begin
                    errc_n = err_count + CNT_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        a_n    = (state_n == ARM);
        d_n    = (state_n == STROBE);
        done_n = (state_n == DONE);
        busy_n = (state_n != IDLE);
        b_n    = 1'b0;
        c_n    = 1'b0;
        if (state_n == STROBE) begin
            b_n = ~err_q & ~sel;
            c_n = ~err_q & sel;
        end else if (state_n == HOLD) begin
            b_n = b;
            c_n = c;
        end
    end

endmodule

// File: tb/tb_trigger_seq_gen.sv
// Scoreboard bench for trigger_seq_gen: stimulus pushes expected sequences,
// a negedge monitor pops them on each a pulse and checks timing, qualifiers and counters.
module tb_trigger_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] delay;
    logic       inject_err;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       busy;
    logic       done;
    logic [7:0] seq_count;
    logic [7:0] err_count;

    trigger_seq_gen #(.DLY_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .delay      (delay),
        .inject_err (inject_err),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .busy       (busy),
        .done       (done),
        .seq_count  (seq_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dly;
        bit         err;
        bit         use_c;
        logic [7:0] seq;
        logic [7:0] errc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_seq = 8'd0;
    logic [7:0] m_errc = 8'd0;
    bit         m_sel = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Monitor state
    int       cyc = 0;
    int       a_cyc = 0;
    int       d_cyc = -1000;
    int       last_done_cyc = -1000;
    bit       cur_valid = 1'b0;
    bit       in_seq = 1'b0;
    bit       hold_chk = 1'b0;
    bit       prev_a = 1'b0;
    bit       prev_d = 1'b0;
    bit       prev_done = 1'b0;
    logic [1:0] exp_bc = 2'b00;

    always @(negedge clk) begin
        if (rst) begin
            cur_valid     = 1'b0;
            in_seq        = 1'b0;
            hold_chk      = 1'b0;
            prev_a        = 1'b0;
            prev_d        = 1'b0;
            prev_done     = 1'b0;
            last_done_cyc = -1000;
            exp_q.delete();
        end else begin
            cyc++;
            if (a) begin
                check_eq("a_width", 32'(prev_a), 32'd0);
                check_eq("idle_gap", 32'(cyc - last_done_cyc >= 2), 32'd1);
                if (exp_q.size() == 0) begin
                    check_eq("a_unexpected", 32'd1, 32'd0);
                end else begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    in_seq    = 1'b1;
                    a_cyc     = cyc;
                    d_cyc     = -1000;
                    exp_bc    = cur.err ? 2'b00 : (cur.use_c ? 2'b01 : 2'b10);
                end
            end
            check_eq("busy", 32'(busy), 32'(in_seq));
            if (d) begin
                check_eq("d_width", 32'(prev_d), 32'd0);
                if (!cur_valid) begin
                    check_eq("d_unexpected", 32'd1, 32'd0);
                end else begin
                    check_eq("d_timing", 32'(cyc - a_cyc), 32'(1 + cur.dly));
                    check_eq("qual_strobe", 32'({b, c}), 32'(exp_bc));
                    d_cyc    = cyc;
                    hold_chk = 1'b1;
                end
            end else if (hold_chk) begin
                check_eq("qual_hold", 32'({b, c}), 32'(exp_bc));
                hold_chk = 1'b0;
            end else begin
                check_eq("qual_idle", 32'({b, c}), 32'd0);
            end
            if (done) begin
                check_eq("done_width", 32'(prev_done), 32'd0);
                if (!cur_valid) begin
                    check_eq("done_unexpected", 32'd1, 32'd0);
                end else begin
                    check_eq("done_timing", 32'(cyc - d_cyc), 32'd2);
                    check_eq("seq_count", 32'(seq_count), 32'(cur.seq));
                    check_eq("err_count", 32'(err_count), 32'(cur.errc));
                    cur_valid = 1'b0;
                end
                in_seq        = 1'b0;
                last_done_cyc = cyc;
            end
            prev_a    = a;
            prev_d    = d;
            prev_done = done;
        end
    end

    task automatic push_exp(input int dly, input bit ie);
        exp_t e;
        m_seq = m_seq + 8'd1;
        if (ie) m_errc = m_errc + 8'd1;
        e.dly   = dly;
        e.err   = ie;
        e.use_c = m_sel;
        e.seq   = m_seq;
        e.errc  = m_errc;
        m_sel   = ~m_sel;
        exp_q.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle start; inputs are scrambled right after acceptance
    task automatic launch(input int dly, input bit ie);
        push_exp(dly, ie);
        delay      = 4'(dly);
        inject_err = ie;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        delay      = 4'($urandom);
        inject_err = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_outs", 32'({a, b, c, d, busy, done}), 32'd0);
        check_eq("rst_seq", 32'(seq_count), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_seq  = 8'd0;
        m_errc = 8'd0;
        m_sel  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_open"}, 32'(cur_valid), 32'd0);
        check_eq({tag, "_seq"}, 32'(seq_count), 32'(m_seq));
        check_eq({tag, "_err"}, 32'(err_count), 32'(m_errc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dly;
        bit ie;
        rst        = 1'b1;
        start      = 1'b0;
        delay      = 4'd0;
        inject_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("init_outs", 32'({a, b, c, d, busy, done}), 32'd0);
        check_eq("init_cnts", 32'({seq_count, err_count}), 32'd0);
        rst = 1'b0;
        settle(2);

        // delay=3, no error
        launch(3, 1'b0);
        settle(8);
        check_idle("d3");

        // Two zero-delay sequences: b then c
        do_reset();
        launch(0, 1'b0);
        settle(5);
        launch(0, 1'b0);
        settle(5);
        check_idle("d0x2");
        check_eq("d0x2_count", 32'(seq_count), 32'd2);

        // Injected error
        do_reset();
        launch(2, 1'b1);
        settle(7);
        check_idle("inj");
        check_eq("inj_err", 32'(err_count), 32'd1);

        // start during WAIT is ignored
        launch(6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        settle(7);
        check_idle("ign");

        for (int i = 0; i < 6; i++) begin
            dly = int'($urandom_range(0, 15));
            ie  = 1'($urandom_range(0, 1));
            launch(dly, ie);
            settle(dly + 5);
            check_idle("rnd");
        end

        // Reset mid-WAIT, then full-length delay
        launch(15, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        launch(15, 1'b0);
        settle(20);
        check_idle("max");

        // start held for exactly 300 zero-delay sequences
        do_reset();
        for (int i = 0; i < 300; i++) push_exp(0, 1'b0);
        delay      = 4'd0;
        inject_err = 1'b0;
        start      = 1'b1;
        repeat (1498) @(posedge clk);
        #1;
        start = 1'b0;
        settle(10);
        check_idle("held");
        check_eq("held_wrap", 32'(seq_count), 32'd44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trigger_seq_gen.md
TRIGGER_SEQ_GEN -- requirements
Module: trigger_seq_gen

Interface
REQ-001 The block SHALL have parameter DLY_W, default 4, giving the width of the delay input.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the sequence and error counters.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start, input, 1 bit: request one trigger sequence; sampled on posedge clk.
REQ-006 Port delay, input, DLY_W bits: number of cycles between the end of the a pulse and the d strobe.
REQ-007 Port inject_err, input, 1 bit: when set at start, the sequence drives b=c=0 at the strobe.
REQ-008 Port a, output, 1 bit: arm pulse.
REQ-009 Port b, output, 1 bit: qualifier, used on even-numbered sequences.
REQ-010 Port c, output, 1 bit: qualifier, used on odd-numbered sequences.
REQ-011 Port d, output, 1 bit: strobe; the checking side samples b||c on its edge.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: one-cycle pulse at sequence completion.
REQ-014 Port seq_count, output, CNT_W bits: number of completed sequences.
REQ-015 Port err_count, output, CNT_W bits: number of completed sequences that ran with inject_err.

Function
REQ-016 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-017 The FSM SHALL have exactly the states IDLE, ARM, WAIT, STROBE, HOLD and DONE.
REQ-018 IDLE: when start=1, the block SHALL latch delay, latch inject_err and go to ARM; otherwise it SHALL stay in IDLE.
REQ-019 ARM: a=1 for exactly one cycle; next state SHALL be STROBE if the latched delay is 0, else WAIT with the down-counter loaded with the latched delay.
REQ-020 WAIT: the counter SHALL decrement each cycle; when counter==1, next state SHALL be STROBE; a, b, c and d SHALL be 0 throughout WAIT.
REQ-021 Timing: if a is high in cycle N, d SHALL be high in cycle N+1+delay.
REQ-022 STROBE: d=1 for exactly one cycle, with the qualifier set in the same cycle.
REQ-023 Qualifier selection: b=1 if the sel toggle is 0, c=1 if sel is 1; b=c=0 if the latched inject_err=1; b and c SHALL never be 1 together.
REQ-024 HOLD: d=0 and b/c SHALL keep their STROBE values for one cycle, so the qualifier is stable on both edges of d.
REQ-025 DONE: done=1 for one cycle; seq_count SHALL increment; err_count SHALL increment if the latched inject_err=1; sel SHALL toggle; b and c SHALL clear; next state SHALL be IDLE.
REQ-026 Both counters SHALL wrap modulo 2^CNT_W.
REQ-027 start SHALL be ignored while busy=1; a request is not queued.
REQ-028 start=1 held continuously SHALL launch back-to-back sequences, each with at least one IDLE cycle between DONE and the next ARM.
REQ-029 Changes on delay or inject_err after the ARM cycle SHALL not affect the sequence in progress.
REQ-030 The maximum delay (2^DLY_W-1) SHALL place the strobe 2^DLY_W cycles after the a pulse, with no counter overflow.

Reset
REQ-031 While rst=1, the state SHALL be IDLE and a, b, c, d, busy, done, seq_count, err_count, sel and the delay counter SHALL all be 0, independent of clk.
REQ-032 rst asserted mid-sequence SHALL abort the sequence immediately, with no done pulse and no counter increment.
REQ-033 After rst deasserts, the first start sampled on a posedge SHALL begin a fresh sequence from ARM using b.

Verification
REQ-034 Reset then start=1 for one cycle with delay=3, inject_err=0 -> a high in cycle N, d high in N+4, b=1 in N+4..N+5, c=0, done in N+6, seq_count=1, err_count=0.
REQ-035 Two sequences with delay=0 -> d in the cycle immediately after a; the first sequence uses b, the second uses c; seq_count=2.
REQ-036 inject_err=1, delay=2 -> b=c=0 while d=1; err_count=1, seq_count=1.
REQ-037 start pulsed during WAIT -> ignored; exactly one done pulse; seq_count increments once.
REQ-038 rst pulsed during WAIT with delay=15 -> all outputs 0 at once, no done pulse; the next start produces d exactly 16 cycles after a, using b.
REQ-039 start held high for 300 sequences, CNT_W=8 -> seq_count wraps to 44; every d cycle has b XOR c = 1; a, d and done are each always one-cycle pulses.
